// File: rtl/vga_pkg.sv
// Shared definitions for the VGA generator, its pattern sequencer and the board top level.
package vga_pkg;

  localparam int PAT_W        = 2;
  localparam int NUM_PATTERNS = 4;

  typedef logic [PAT_W-1:0] pat_sel_t;

  // Mode FSM encoding; o_auto is the decoded view of this state.
  localparam logic [0:0] MODE_AUTO   = 1'b0;
  localparam logic [0:0] MODE_MANUAL = 1'b1;

  function automatic pat_sel_t next_pat(input pat_sel_t s);
    return (s == pat_sel_t'(NUM_PATTERNS - 1)) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw push-button, filters bounce and emits a one-cycle press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q, press_d;

  // The count only runs while the synchronized input disagrees with the
  // accepted level, so any return to the old level restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == C_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-aligned pattern select for the VGA generator: slideshow timer, next button
// and host requests, with every change applied only at a vsync frame boundary.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter bit VSYNC_ACTIVE_LOW   = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_btn_next,
  input  logic             i_btn_mode,
  input  logic             i_req_valid,
  input  logic [PAT_W-1:0] i_req_sel,
  output logic [PAT_W-1:0] o_sel,
  output logic             o_auto,
  output logic             o_req_pending,
  output logic             o_frame_tick
);

  localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic VS_ACT  = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic VS_IDLE = ~VS_ACT;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge CLOCK_50 or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic next_press, mode_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk_i  (CLOCK_50),
    .rst_ni (rst_n_int),
    .btn_i  (i_btn_next),
    .press_o(next_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_i  (CLOCK_50),
    .rst_ni (rst_n_int),
    .btn_i  (i_btn_mode),
    .press_o(mode_press)
  );

  logic [1:0]       vs_sync_q;
  logic             vs_prev_q;
  logic             tick_q, tick_d;
  logic [0:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pat_sel_t         sel_q, sel_d;
  pat_sel_t         pend_val_q, pend_val_d;
  logic             pend_direct_q, pend_direct_d;
  logic             pend_next_q, pend_next_d;
  logic             applied;

  assign tick_d = (vs_sync_q[1] == VS_ACT) && (vs_prev_q != VS_ACT);

  // Arbitration uses only flags captured before the tick cycle; anything
  // arriving alongside the tick is queued for the following frame.
  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      mode_d = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
    end

    sel_d   = sel_q;
    cnt_d   = cnt_q;
    applied = 1'b0;
    if (tick_q) begin
      if (pend_direct_q) begin
        sel_d   = pend_val_q;
        applied = 1'b1;
      end else if (pend_next_q) begin
        sel_d   = next_pat(sel_q);
        applied = 1'b1;
      end else if ((mode_q == MODE_AUTO) && (cnt_q == CNT_LAST)) begin
        sel_d   = next_pat(sel_q);
        applied = 1'b1;
      end
      if (mode_q == MODE_AUTO) begin
        cnt_d = (applied || (cnt_q == CNT_LAST)) ? '0 : cnt_q + 1'b1;
      end
    end
    if (mode_press && (mode_q == MODE_MANUAL)) begin
      cnt_d = '0;
    end

    pend_direct_d = (tick_q ? 1'b0 : pend_direct_q) | i_req_valid;
    pend_next_d   = (tick_q ? 1'b0 : pend_next_q) | next_press;
    pend_val_d    = i_req_valid ? i_req_sel : pend_val_q;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      vs_sync_q     <= {VS_IDLE, VS_IDLE};
      vs_prev_q     <= VS_IDLE;
      tick_q        <= 1'b0;
      mode_q        <= MODE_AUTO;
      cnt_q         <= '0;
      sel_q         <= '0;
      pend_val_q    <= '0;
      pend_direct_q <= 1'b0;
      pend_next_q   <= 1'b0;
    end else begin
      vs_sync_q     <= {vs_sync_q[0], i_vsync};
      vs_prev_q     <= vs_sync_q[1];
      tick_q        <= tick_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      pend_val_q    <= pend_val_d;
      pend_direct_q <= pend_direct_d;
      pend_next_q   <= pend_next_d;
    end
  end

  assign o_sel         = sel_q;
  assign o_auto        = (mode_q == MODE_AUTO);
  assign o_req_pending = pend_direct_q;
  assign o_frame_tick  = tick_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer with FRAMES_PER_PATTERN=3, DEBOUNCE_CYCLES=4.
module tb_vga_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       btn_next;
  logic       btn_mode;
  logic       req_valid;
  logic [1:0] req_sel;
  logic [1:0] sel;
  logic       auto_m;
  logic       req_pend;
  logic       ftick;

  int         n_checks = 0;
  int         n_errors = 0;
  int         tick_cnt = 0;
  int         tick_k   = 0;
  logic [1:0] sel_at_tick;
  logic [1:0] sel_after;

  always #5 clk = ~clk;

  vga_pattern_sequencer #(
    .FRAMES_PER_PATTERN(3),
    .DEBOUNCE_CYCLES   (4),
    .VSYNC_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLOCK_50     (clk),
    .i_rst_n      (rst_n),
    .i_vsync      (vsync),
    .i_btn_next   (btn_next),
    .i_btn_mode   (btn_mode),
    .i_req_valid  (req_valid),
    .i_req_sel    (req_sel),
    .o_sel        (sel),
    .o_auto       (auto_m),
    .o_req_pending(req_pend),
    .o_frame_tick (ftick)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: active-low vsync for 4 cycles, then idle. Optionally raise a
  // direct request exactly in the tick cycle.
  task automatic do_frame(input bit req_at_tick, input logic [1:0] rsel);
    tick_k = 0;
    @(negedge clk);
    vsync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (tick_k != 0 && k == tick_k + 1) sel_after = sel;
      if (ftick) begin
        tick_cnt++;
        if (tick_k == 0) tick_k = k;
        sel_at_tick = sel;
        if (req_at_tick) begin
          req_valid = 1'b1;
          req_sel   = rsel;
        end
      end
      if (k == 4) vsync = 1'b1;
    end
  endtask

  task automatic press_btn(input bit is_mode);
    @(negedge clk);
    if (is_mode) btn_mode = 1'b1; else btn_next = 1'b1;
    repeat (8) @(negedge clk);
    if (is_mode) btn_mode = 1'b0; else btn_next = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic glitch(input int hi, input int lo);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (hi) @(negedge clk);
    btn_next = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_req(input logic [1:0] s);
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    vsync     = 1'b1;
    btn_next  = 1'b0;
    btn_mode  = 1'b0;
    req_valid = 1'b0;
    req_sel   = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_sel",  8'(sel), 8'd0);
    check("rst_auto", 8'(auto_m), 8'd1);
    check("rst_pend", 8'(req_pend), 8'd0);
    check("rst_tick", 8'(ftick), 8'd0);

    // Auto advance every 3 frames, wrapping after 12.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ftick) tick_cnt++;
    end
    check("no_tick_at_release", 8'(tick_cnt), 8'd0);
    do_frame(1'b0, 2'd0);
    check("vsync_latency", 8'(tick_k), 8'd3);
    check("one_tick_per_frame", 8'(tick_cnt), 8'd1);
    do_frame(1'b0, 2'd0);
    check("auto_f2_sel", 8'(sel), 8'd0);
    do_frame(1'b0, 2'd0);
    check("auto_f3_sel_at_tick", 8'(sel_at_tick), 8'd0);
    check("auto_f3_sel_after", 8'(sel_after), 8'd1);
    for (int i = 0; i < 9; i++) do_frame(1'b0, 2'd0);
    check("auto_wrap_sel", 8'(sel), 8'd0);
    check("auto_tick_count", 8'(tick_cnt), 8'd12);

    // Direct request beats a pending next; counter restarts.
    press_btn(1'b0);
    send_req(2'd2);
    check("arb_pend_rise", 8'(req_pend), 8'd1);
    do_frame(1'b0, 2'd0);
    check("arb_direct_sel", 8'(sel_after), 8'd2);
    check("arb_pend_fall", 8'(req_pend), 8'd0);
    do_frame(1'b0, 2'd0);
    check("arb_next_dropped", 8'(sel), 8'd2);
    do_frame(1'b0, 2'd0);
    check("arb_cnt_restart", 8'(sel), 8'd2);
    do_frame(1'b0, 2'd0);
    check("arb_auto_after3", 8'(sel), 8'd3);

    // Short button glitches are filtered; a long hold gives one advance.
    glitch(1, 3);
    glitch(2, 3);
    glitch(3, 6);
    do_frame(1'b0, 2'd0);
    check("db_glitch_no_press", 8'(sel), 8'd3);
    glitch(7, 8);
    do_frame(1'b0, 2'd0);
    check("db_hold_wrap", 8'(sel_after), 8'd0);
    do_frame(1'b0, 2'd0);
    check("db_single_advance", 8'(sel), 8'd0);

    // Manual mode holds the pattern; presses collapse within a frame.
    press_btn(1'b1);
    check("man_auto_low", 8'(auto_m), 8'd0);
    for (int i = 0; i < 10; i++) do_frame(1'b0, 2'd0);
    check("man_sel_hold", 8'(sel), 8'd0);
    press_btn(1'b0);
    press_btn(1'b0);
    do_frame(1'b0, 2'd0);
    check("man_next_once", 8'(sel), 8'd1);
    do_frame(1'b0, 2'd0);
    check("man_next_collapsed", 8'(sel), 8'd1);
    press_btn(1'b1);
    check("man_auto_back", 8'(auto_m), 8'd1);
    do_frame(1'b0, 2'd0);
    do_frame(1'b0, 2'd0);
    check("man_cnt_cleared", 8'(sel), 8'd1);
    do_frame(1'b0, 2'd0);
    check("man_auto_resume", 8'(sel), 8'd2);

    // Request in the tick cycle waits for the next frame.
    do_frame(1'b1, 2'd3);
    check("col_sel_unchanged", 8'(sel_after), 8'd2);
    check("col_pend_kept", 8'(req_pend), 8'd1);
    do_frame(1'b0, 2'd0);
    check("col_sel_applied", 8'(sel), 8'd3);
    check("col_pend_clear", 8'(req_pend), 8'd0);

    // Reset with a request pending.
    send_req(2'd2);
    do_frame(1'b0, 2'd0);
    check("rstp_sel2", 8'(sel), 8'd2);
    send_req(2'd1);
    check("rstp_pend", 8'(req_pend), 8'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstp_sel", 8'(sel), 8'd0);
    check("rstp_auto", 8'(auto_m), 8'd1);
    check("rstp_pend_clr", 8'(req_pend), 8'd0);
    check("rstp_tick", 8'(ftick), 8'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tick_cnt = 0;
    do_frame(1'b0, 2'd0);
    check("rstp_tick_seen", 8'(tick_cnt), 8'd1);
    check("rstp_no_apply", 8'(sel), 8'd0);
    check("rstp_pend_after", 8'(req_pend), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
